// File: rtl/sym_window_eval.sv
// rtl/sym_window_eval.sv - two-stage elastic popcount/window evaluator for totally symmetric functions
// Optional statistics counters are built when SYM_WINDOW_EVAL_STATS_EN is defined.
module sym_window_eval #(
  parameter int WIDTH  = 9,
  parameter int DEF_LO = 3,
  parameter int DEF_HI = 6,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             cfg_we,
  input  logic [CW-1:0]    cfg_lo,
  input  logic [CW-1:0]    cfg_hi,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_match,
  output logic [CW-1:0]    out_count,
  input  logic             stats_clr,
  output logic [15:0]      sample_cnt,
  output logic [15:0]      hit_cnt
);

  logic          s1_valid;
  logic [CW-1:0] s1_count;
  logic          s2_valid;
  logic [CW-1:0] s2_count;
  logic          s2_match;
  logic [CW-1:0] lo_q;
  logic [CW-1:0] hi_q;
  logic          s1_ready;
  logic          s2_ready;
  logic [CW-1:0] pop;
  logic          in_window;

  // Ready ripples combinationally from the output back to the input; no skid buffer.
  assign s2_ready = !s2_valid || out_ready;
  assign s1_ready = !s1_valid || s2_ready;
  assign in_ready = s1_ready;

  always_comb begin
    pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop = pop + CW'(in_data[i]);
    end
  end

  // An inverted window (lo > hi) can never satisfy both comparisons.
  assign in_window = (s1_count >= lo_q) && (s1_count <= hi_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_count <= '0;
      s2_valid <= 1'b0;
      s2_count <= '0;
      s2_match <= 1'b0;
      lo_q     <= CW'(DEF_LO);
      hi_q     <= CW'(DEF_HI);
    end else begin
      if (s1_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_count <= pop;
        end
      end
      if (s2_ready) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_count <= s1_count;
          s2_match <= in_window;
        end
      end
      if (cfg_we) begin
        lo_q <= cfg_lo;
        hi_q <= cfg_hi;
      end
    end
  end

  assign out_valid = s2_valid;
  assign out_count = s2_count;
  assign out_match = s2_match;

`ifdef SYM_WINDOW_EVAL_STATS_EN
  logic [15:0] sample_q;
  logic [15:0] hit_q;
  logic        out_fire;

  assign out_fire = s2_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n || stats_clr) begin
      sample_q <= '0;
      hit_q    <= '0;
    end else if (out_fire) begin
      if (sample_q != 16'hFFFF) begin
        sample_q <= sample_q + 16'd1;
      end
      if (s2_match && (hit_q != 16'hFFFF)) begin
        hit_q <= hit_q + 16'd1;
      end
    end
  end

  assign sample_cnt = sample_q;
  assign hit_cnt    = hit_q;
`else
  logic unused_stats_clr;
  assign unused_stats_clr = stats_clr;
  assign sample_cnt       = '0;
  assign hit_cnt          = '0;
`endif

endmodule

// File: tb/tb_sym_window_eval.sv
// tb/tb_sym_window_eval.sv - self-checking bench for sym_window_eval (default WIDTH=9 window 3..6)
// Statistics expectations follow SYM_WINDOW_EVAL_STATS_EN.
module tb_sym_window_eval;
  localparam int WIDTH = 9;
  localparam int CW    = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             cfg_we = 1'b0;
  logic [CW-1:0]    cfg_lo = '0;
  logic [CW-1:0]    cfg_hi = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic             out_match;
  logic [CW-1:0]    out_count;
  logic             stats_clr = 1'b0;
  logic [15:0]      sample_cnt;
  logic [15:0]      hit_cnt;

  always #5 clk = ~clk;

  sym_window_eval #(.WIDTH(WIDTH), .DEF_LO(3), .DEF_HI(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .cfg_we(cfg_we), .cfg_lo(cfg_lo), .cfg_hi(cfg_hi),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_match(out_match), .out_count(out_count),
    .stats_clr(stats_clr), .sample_cnt(sample_cnt), .hit_cnt(hit_cnt)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: each accepted word is scored against the window in force when it was accepted.
  typedef struct packed { logic [CW-1:0] count; logic match; } res_t;
  res_t exp_q[$];
  int   m_lo = 3, m_hi = 6;
  int   m_sample = 0, m_hit = 0;
  int   n_results = 0, n_hits = 0;
  logic held_v = 1'b0;
  logic [CW-1:0] held_c = '0;
  logic held_m = 1'b0;

  always @(negedge clk) begin
    res_t e;
    int   c;
    if (!rst_n) begin
      exp_q.delete();
      m_lo = 3; m_hi = 6; m_sample = 0; m_hit = 0; held_v = 1'b0;
    end else begin
      check("sample_cnt", sample_cnt, m_sample);
      check("hit_cnt", hit_cnt, m_hit);
      if (held_v) begin
        check("hold_valid", out_valid, 1);
        check("hold_count", out_count, held_c);
        check("hold_match", out_match, held_m);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_result: got count %0d with empty scoreboard", out_count);
        end else begin
          e = exp_q.pop_front();
          check("sb_count", out_count, e.count);
          check("sb_match", out_match, e.match);
          n_results++;
          if (out_match) n_hits++;
`ifdef SYM_WINDOW_EVAL_STATS_EN
          if (m_sample < 65535) m_sample++;
          if (e.match && m_hit < 65535) m_hit++;
`endif
        end
      end
      held_v = out_valid && !out_ready;
      held_c = out_count;
      held_m = out_match;
      if (in_valid && in_ready) begin
        c = $countones(in_data);
        e.count = CW'(c);
        e.match = (c >= m_lo) && (c <= m_hi);
        exp_q.push_back(e);
      end
      if (cfg_we) begin
        m_lo = int'(cfg_lo);
        m_hi = int'(cfg_hi);
      end
      if (stats_clr) begin
        m_sample = 0; m_hit = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int stalls = 0;

  task automatic send(input logic [WIDTH-1:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 200) begin
      tick();
      n++;
      stalls++;
    end
    if (n == 200) check("send_timeout", 0, 1);
    tick();
  endtask

  task automatic drain();
    int n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && n < 300) begin
      tick();
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic set_window(input logic [CW-1:0] lo, input logic [CW-1:0] hi);
    cfg_we = 1'b1; cfg_lo = lo; cfg_hi = hi;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic pulse_clr();
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
  endtask

  typedef struct { logic [WIDTH-1:0] data; logic [CW-1:0] cnt; logic m; } vec_t;
  vec_t vt[7];

  task automatic run_table();
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_data  = vt[i].data;
      tick();
      in_valid = 1'b0;
      check("lat_valid_n1", out_valid, 0);
      tick();
      check("lat_valid_n2", out_valid, 1);
      check("tbl_count", out_count, vt[i].cnt);
      check("tbl_match", out_match, vt[i].m);
    end
    tick();
  endtask

  task automatic sweep(input int exp_hits);
    int r0, h0;
    pulse_clr();
    r0 = n_results; h0 = n_hits; stalls = 0;
    for (int w = 0; w < 512; w++) send(WIDTH'(w));
    in_valid = 1'b0;
    check("sweep_stalls", stalls, 0);
    drain();
    check("sweep_results", n_results - r0, 512);
    check("sweep_hits", n_hits - h0, exp_hits);
`ifdef SYM_WINDOW_EVAL_STATS_EN
    check("sweep_sample_cnt", sample_cnt, 512);
    check("sweep_hit_cnt", hit_cnt, exp_hits);
`else
    check("sweep_sample_cnt", sample_cnt, 0);
    check("sweep_hit_cnt", hit_cnt, 0);
`endif
  endtask

  initial begin
    logic acc;
    vt[0] = '{9'h007, 4'd3, 1'b1};
    vt[1] = '{9'h1FF, 4'd9, 1'b0};
    vt[2] = '{9'h000, 4'd0, 1'b0};
    vt[3] = '{9'h0F0, 4'd4, 1'b1};
    vt[4] = '{9'h03F, 4'd6, 1'b1};
    vt[5] = '{9'h07F, 4'd7, 1'b0};
    vt[6] = '{9'h003, 4'd2, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_count", out_count, 0);
    check("rst_out_match", out_match, 0);
    check("rst_sample_cnt", sample_cnt, 0);
    check("rst_hit_cnt", hit_cnt, 0);
    rst_n = 1'b1;
    check("rst_in_ready", in_ready, 1);

    run_table();

    // Window write in the same cycle the word moves S1->S2: old window applies.
    in_valid = 1'b1; in_data = '0;
    tick();
    in_valid = 1'b0;
    cfg_we = 1'b1; cfg_lo = '0; cfg_hi = '0;
    tick();
    cfg_we = 1'b0;
    check("win_old_valid", out_valid, 1);
    check("win_old_match", out_match, 0);
    in_valid = 1'b1; in_data = '0;
    tick();
    in_valid = 1'b0;
    tick();
    check("win_new_valid", out_valid, 1);
    check("win_new_match", out_match, 1);
    tick();
    set_window(4'd3, 4'd6);

    // Backpressure: two words absorbed, third waits.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 9'h001;
    tick();
    check("bp_ready_after_1", in_ready, 1);
    in_data = 9'h003;
    tick();
    check("bp_ready_after_2", in_ready, 0);
    in_data = 9'h007;
    repeat (3) tick();
    check("bp_ready_held", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    check("bp_out_count", out_count, 1);
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    drain();

    sweep(420);
    set_window(4'd5, 4'd2);
    sweep(0);

    // Randomized traffic with random windows, backpressure and counter clears.
    for (int r = 0; r < 4; r++) begin
      set_window(CW'($urandom_range(0, 15)), CW'($urandom_range(0, 15)));
      acc = 1'b0;
      for (int k = 0; k < 400; k++) begin
        if (!in_valid || acc) begin
          in_valid = ($urandom % 3) != 0;
          in_data  = WIDTH'($urandom);
        end
        out_ready = ($urandom % 4) != 0;
        stats_clr = ($urandom % 40) == 0;
        #1;
        acc = in_valid && in_ready;
        tick();
      end
      stats_clr = 1'b0;
      drain();
    end

    // Reset with both stages full and a word waiting.
    set_window(4'd5, 4'd2);
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 9'h00F;
    tick();
    in_data = 9'h01F;
    tick();
    check("full_out_valid", out_valid, 1);
    rst_n = 1'b0;
    tick();
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_count", out_count, 0);
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (5) tick();
    check("midrst_no_stale", out_valid, 0);
    run_table();

    // Saturation, then clear with a same-cycle handshake.
    pulse_clr();
    in_valid = 1'b1;
    for (int k = 0; k < 70000; k++) begin
      in_data = WIDTH'($urandom);
      tick();
    end
`ifdef SYM_WINDOW_EVAL_STATS_EN
    check("sat_sample_cnt", sample_cnt, 16'hFFFF);
`else
    check("sat_sample_cnt", sample_cnt, 0);
`endif
    check("sat_out_valid", out_valid, 1);
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    check("clr_sample_cnt", sample_cnt, 0);
    check("clr_hit_cnt", hit_cnt, 0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1);
  end

endmodule
